// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared types and row-to-points table for the brick scorer
package breakout_pkg;

  // Scorer sequencing states
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ADD,
    WALL
  } state_t;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [2:0] row_t;
  typedef logic [2:0] points_t;

  // Rows pair up top to bottom: 7, 5, 3, 1 points
  function automatic points_t row_points(input row_t row);
    points_t p;
    case (row[2:1])
      2'd0:    p = 3'd7;
      2'd1:    p = 3'd5;
      2'd2:    p = 3'd3;
      default: p = 3'd1;
    endcase
    return p;
  endfunction

  // Single BCD digit increment, 9 rolls to 0
  function automatic bcd_digit_t bcd_digit_inc(input bcd_digit_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/brick_score_if.sv
// rtl/brick_score_if.sv - hit input and score output bundle between playfield and scorer
interface brick_score_if;
  logic        BRICK_HIT;
  logic [2:0]  BRICK_ROW;
  logic        RAM_PLAYER1;
  logic        START_GAME;
  logic        ATTRACT_N;
  logic [11:0] SCORE1;
  logic [11:0] SCORE2;
  logic        WALL_CLEARED;
  logic        BUSY;
  logic        HIT_OVERRUN;

  modport master (
    output BRICK_HIT, BRICK_ROW, RAM_PLAYER1, START_GAME, ATTRACT_N,
    input  SCORE1, SCORE2, WALL_CLEARED, BUSY, HIT_OVERRUN
  );

  modport slave (
    input  BRICK_HIT, BRICK_ROW, RAM_PLAYER1, START_GAME, ATTRACT_N,
    output SCORE1, SCORE2, WALL_CLEARED, BUSY, HIT_OVERRUN
  );
endinterface

// File: rtl/bcd_counter3.sv
// rtl/bcd_counter3.sv - three-digit BCD incrementer with synchronous clear and optional hold at 999
module bcd_counter3
  import breakout_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  input  logic        sat_en,
  output logic [11:0] value
);

  bcd_digit_t  d0, d1, d2;
  logic        at_max;
  logic [11:0] nxt;

  assign d0     = value[3:0];
  assign d1     = value[7:4];
  assign d2     = value[11:8];
  assign at_max = (value == 12'h999);

  // Ripple the carry digit by digit; 999 either wraps to 000 or holds when saturating
  always_comb begin
    nxt = value;
    if (inc && !(sat_en && at_max)) begin
      nxt[3:0] = bcd_digit_inc(d0);
      if (d0 == 4'd9) begin
        nxt[7:4] = bcd_digit_inc(d1);
        if (d1 == 4'd9) begin
          nxt[11:8] = bcd_digit_inc(d2);
        end
      end
    end
  end

  // Score register; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/brick_score.sv
// rtl/brick_score.sv - breakout brick scorer; define BRICK_SCORE_SATURATE_EN to hold scores at 999
module brick_score
  import breakout_pkg::*;
#(
  parameter int BRICKS_PER_WALL = 112
) (
  input  logic         CLK_DRV,
  input  logic         RESET_N,
  brick_score_if.slave io
);

  localparam int               CNT_W    = $clog2(BRICKS_PER_WALL + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BRICKS_PER_WALL);

  state_t           state;
  logic             hit_q;
  logic             detect;
  logic             cur_player;
  row_t             cur_row;
  points_t          pts;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cur_cnt;
  logic             pend_valid;
  logic             pend_player;
  row_t             pend_row;
  logic             wall_cleared;
  logic             hit_overrun;
  logic             inc1;
  logic             inc2;
  logic             sat_en;

`ifdef BRICK_SCORE_SATURATE_EN
  assign sat_en = 1'b1;
`else
  assign sat_en = 1'b0;
`endif

  // A hit is a rising level while scoring is enabled; a new game swallows it
  assign detect  = io.BRICK_HIT & ~hit_q & io.ATTRACT_N & ~io.START_GAME;
  assign cur_cnt = cur_player ? cnt1 : cnt2;
  assign inc1    = (state == ADD) &  cur_player;
  assign inc2    = (state == ADD) & ~cur_player;

  assign io.BUSY         = (state != IDLE);
  assign io.WALL_CLEARED = wall_cleared;
  assign io.HIT_OVERRUN  = hit_overrun;

  // Previous BRICK_HIT sample; resets high so a level held through reset is not an edge
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_q <= 1'b1;
    end else begin
      hit_q <= io.BRICK_HIT;
    end
  end

  // Scoring sequencer: latch a hit, load its points, count up one per cycle, flag cleared walls
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      cur_player   <= 1'b0;
      cur_row      <= '0;
      pts          <= '0;
      cnt1         <= '0;
      cnt2         <= '0;
      pend_valid   <= 1'b0;
      pend_player  <= 1'b0;
      pend_row     <= '0;
      wall_cleared <= 1'b0;
      hit_overrun  <= 1'b0;
    end else if (io.START_GAME) begin
      state        <= IDLE;
      pts          <= '0;
      cnt1         <= '0;
      cnt2         <= '0;
      pend_valid   <= 1'b0;
      wall_cleared <= 1'b0;
      hit_overrun  <= 1'b0;
    end else begin
      wall_cleared <= 1'b0;
      hit_overrun  <= 1'b0;

      case (state)
        IDLE: begin
          if (pend_valid && io.ATTRACT_N) begin
            // Serve the queued hit; a hit arriving now takes over the freed slot
            state      <= LOAD;
            cur_player <= pend_player;
            cur_row    <= pend_row;
            if (detect) begin
              pend_player <= io.RAM_PLAYER1;
              pend_row    <= io.BRICK_ROW;
            end else begin
              pend_valid <= 1'b0;
            end
          end else if (detect) begin
            state      <= LOAD;
            cur_player <= io.RAM_PLAYER1;
            cur_row    <= io.BRICK_ROW;
          end
        end

        LOAD: begin
          pts <= row_points(cur_row);
          if (cur_player) begin
            cnt1 <= cnt1 + CNT_W'(1);
          end else begin
            cnt2 <= cnt2 + CNT_W'(1);
          end
          state <= ADD;
        end

        ADD: begin
          pts <= pts - 3'd1;
          if (pts == 3'd1) begin
            if (cur_cnt == CNT_FULL) begin
              state        <= WALL;
              wall_cleared <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (!io.ATTRACT_N) begin
            // Attract mode cuts the addition short after this cycle's increment
            state <= IDLE;
          end
        end

        WALL: begin
          if (cur_player) begin
            cnt1 <= '0;
          end else begin
            cnt2 <= '0;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Hits arriving while busy queue once; a second one is dropped and flagged
      if (state != IDLE && detect) begin
        if (!pend_valid) begin
          pend_valid  <= 1'b1;
          pend_player <= io.RAM_PLAYER1;
          pend_row    <= io.BRICK_ROW;
        end else begin
          hit_overrun <= 1'b1;
        end
      end

      if (!io.ATTRACT_N) begin
        pend_valid <= 1'b0;
      end
    end
  end

  bcd_counter3 u_score1 (
    .clk    (CLK_DRV),
    .rst_n  (RESET_N),
    .clr    (io.START_GAME),
    .inc    (inc1),
    .sat_en (sat_en),
    .value  (io.SCORE1)
  );

  bcd_counter3 u_score2 (
    .clk    (CLK_DRV),
    .rst_n  (RESET_N),
    .clr    (io.START_GAME),
    .inc    (inc2),
    .sat_en (sat_en),
    .value  (io.SCORE2)
  );

endmodule

// File: tb/tb_brick_score.sv
// tb/tb_brick_score.sv - self-checking bench for brick_score against a decimal score model
module tb_brick_score;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  brick_score_if bus ();

  brick_score #(.BRICKS_PER_WALL(112)) dut (
    .CLK_DRV (clk),
    .RESET_N (rst_n),
    .io      (bus.slave)
  );

  int checks    = 0;
  int errors    = 0;
  int wall_seen = 0;
  int ovr_seen  = 0;

  int m_s1, m_s2, m_c1, m_c2;
  int m_walls = 0;

  // Count output pulse cycles away from the active edge
  always @(negedge clk) begin
    if (bus.WALL_CLEARED === 1'b1) wall_seen++;
    if (bus.HIT_OVERRUN === 1'b1) ovr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_c1 = 0; m_c2 = 0;
  endtask

  // Decimal model: add points, wrap or saturate, count bricks toward a wall
  task automatic model_add(input bit p1, input int pts, input bit count_brick);
    int s;
    s = (p1 ? m_s1 : m_s2) + pts;
`ifdef BRICK_SCORE_SATURATE_EN
    if (s > 999) s = 999;
`else
    s = s % 1000;
`endif
    if (p1) begin
      m_s1 = s;
      if (count_brick) m_c1++;
      if (m_c1 == 112) begin m_c1 = 0; m_walls++; end
    end else begin
      m_s2 = s;
      if (count_brick) m_c2++;
      if (m_c2 == 112) begin m_c2 = 0; m_walls++; end
    end
  endtask

  task automatic model_hit(input int row, input bit p1);
    model_add(p1, 7 - 2 * (row / 2), 1'b1);
  endtask

  // Wait for two consecutive idle samples so a queued hit is not mistaken for completion
  task automatic wait_idle();
    int n = 0;
    int quiet = 0;
    while (quiet < 2 && n < 80) begin
      tick(1);
      n++;
      quiet = (bus.BUSY === 1'b0) ? quiet + 1 : 0;
    end
    check("busy_clear", bus.BUSY, 1'b0);
  endtask

  task automatic do_hit(input int row, input bit p1);
    bus.BRICK_ROW   = row[2:0];
    bus.RAM_PLAYER1 = p1;
    bus.BRICK_HIT   = 1'b1;
    tick(1);
    bus.BRICK_HIT   = 1'b0;
    bus.BRICK_ROW   = 3'($urandom);
    bus.RAM_PLAYER1 = 1'($urandom);
    if (bus.ATTRACT_N) model_hit(row, p1);
    wait_idle();
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_s1"}, bus.SCORE1, to_bcd(m_s1));
    check({tag, "_s2"}, bus.SCORE2, to_bcd(m_s2));
  endtask

  initial begin
    int o0, w0, mw0, row;
    bit p1, att;

    bus.BRICK_HIT   = 1'b1;
    bus.BRICK_ROW   = 3'd0;
    bus.RAM_PLAYER1 = 1'b1;
    bus.START_GAME  = 1'b0;
    bus.ATTRACT_N   = 1'b1;
    model_clear();

    // Reset state with the hit level already high
    tick(3);
    check("rst_score1", bus.SCORE1, 12'h000);
    check("rst_score2", bus.SCORE2, 12'h000);
    check("rst_wall", bus.WALL_CLEARED, 1'b0);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_ovr", bus.HIT_OVERRUN, 1'b0);
    rst_n = 1'b1;
    tick(3);
    check("no_edge_after_rst_busy", bus.BUSY, 1'b0);
    check("no_edge_after_rst_s1", bus.SCORE1, 12'h000);
    bus.BRICK_HIT = 1'b0;
    tick(1);

    bus.START_GAME = 1'b1;
    tick(1);
    bus.START_GAME = 1'b0;
    check_scores("start_game");

    // Row-0 hit for player 1: final score nine edges after the hit rises
    bus.BRICK_ROW = 3'd0; bus.RAM_PLAYER1 = 1'b1; bus.BRICK_HIT = 1'b1;
    tick(1);
    bus.BRICK_HIT = 1'b0; bus.BRICK_ROW = 3'd7; bus.RAM_PLAYER1 = 1'b0;
    tick(7);
    check("row0_edge8_s1", bus.SCORE1, 12'h006);
    check("row0_edge8_busy", bus.BUSY, 1'b1);
    tick(1);
    check("row0_edge9_s1", bus.SCORE1, 12'h007);
    check("row0_edge9_s2", bus.SCORE2, 12'h000);
    check("row0_edge9_busy", bus.BUSY, 1'b0);
    model_hit(0, 1'b1);

    // Row-6 then row-2 for player 2, second hit lands in the pending slot
    o0 = ovr_seen;
    bus.BRICK_ROW = 3'd6; bus.RAM_PLAYER1 = 1'b0; bus.BRICK_HIT = 1'b1;
    tick(1);
    bus.BRICK_HIT = 1'b0;
    tick(1);
    bus.BRICK_ROW = 3'd2; bus.RAM_PLAYER1 = 1'b0; bus.BRICK_HIT = 1'b1;
    tick(1);
    bus.BRICK_HIT = 1'b0; bus.BRICK_ROW = 3'd0; bus.RAM_PLAYER1 = 1'b1;
    model_hit(6, 1'b0);
    model_hit(2, 1'b0);
    wait_idle();
    check("pend_s2", bus.SCORE2, 12'h006);
    check_scores("pend");
    check("pend_no_ovr", ovr_seen - o0, 0);

    // Three hits on alternate cycles: one served, one queued, one dropped
    o0 = ovr_seen;
    for (int k = 0; k < 3; k++) begin
      bus.BRICK_ROW = 3'd0; bus.RAM_PLAYER1 = 1'b1; bus.BRICK_HIT = 1'b1;
      tick(1);
      bus.BRICK_HIT = 1'b0;
      tick(1);
    end
    model_hit(0, 1'b1);
    model_hit(0, 1'b1);
    wait_idle();
    check_scores("overrun");
    check("overrun_pulses", ovr_seen - o0, 1);

    // Attract mode falling mid-addition keeps only the increment already under way
    bus.BRICK_ROW = 3'd0; bus.RAM_PLAYER1 = 1'b1; bus.BRICK_HIT = 1'b1;
    tick(1);
    bus.BRICK_HIT = 1'b0;
    tick(3);
    bus.ATTRACT_N = 1'b0;
    model_add(1'b1, 3, 1'b1);
    wait_idle();
    bus.ATTRACT_N = 1'b1;
    check_scores("attract_abort");

    // 224 row-7 hits: a wall every 112, counter restarting from zero
    bus.START_GAME = 1'b1;
    tick(1);
    bus.START_GAME = 1'b0;
    model_clear();
    w0 = wall_seen; mw0 = m_walls;
    for (int k = 0; k < 112; k++) do_hit(7, 1'b1);
    check("wall112_s1", bus.SCORE1, 12'h112);
    check("wall112_pulses", wall_seen - w0, 1);
    for (int k = 0; k < 111; k++) do_hit(7, 1'b1);
    check("wall223_pulses", wall_seen - w0, 1);
    do_hit(7, 1'b1);
    check("wall224_pulses", wall_seen - w0, 2);
    check("wall_model", wall_seen - w0, m_walls - mw0);
    check_scores("wall224");

    // Build 995 then push past 999
    bus.START_GAME = 1'b1;
    tick(1);
    bus.START_GAME = 1'b0;
    model_clear();
    for (int k = 0; k < 142; k++) do_hit(0, 1'b1);
    do_hit(7, 1'b1);
    check("s1_995", bus.SCORE1, 12'h995);
    do_hit(0, 1'b1);
`ifdef BRICK_SCORE_SATURATE_EN
    check("s1_past_999", bus.SCORE1, 12'h999);
`else
    check("s1_past_999", bus.SCORE1, 12'h002);
`endif
    do_hit(1, 1'b1);
    check_scores("past_999_again");

    // Randomised isolated hits, some during attract mode
    w0 = wall_seen; mw0 = m_walls;
    for (int k = 0; k < 40; k++) begin
      row = $urandom_range(0, 7);
      p1  = 1'($urandom_range(0, 1));
      att = ($urandom_range(0, 5) != 0);
      bus.ATTRACT_N = att;
      do_hit(row, p1);
      bus.ATTRACT_N = 1'b1;
      check_scores("rand");
    end
    check("rand_walls", wall_seen - w0, m_walls - mw0);

    // Reset asserted mid-addition: nothing survives or resumes
    bus.BRICK_ROW = 3'd0; bus.RAM_PLAYER1 = 1'b1; bus.BRICK_HIT = 1'b1;
    tick(1);
    bus.BRICK_HIT = 1'b0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("midadd_rst_s1", bus.SCORE1, 12'h000);
    check("midadd_rst_s2", bus.SCORE2, 12'h000);
    check("midadd_rst_busy", bus.BUSY, 1'b0);
    check("midadd_rst_wall", bus.WALL_CLEARED, 1'b0);
    check("midadd_rst_ovr", bus.HIT_OVERRUN, 1'b0);
    tick(2);
    rst_n = 1'b1;
    model_clear();
    tick(12);
    check("midadd_no_resume_busy", bus.BUSY, 1'b0);
    check_scores("midadd_no_resume");

    // START_GAME on the same cycle as a hit edge: hit ignored, scores cleared
    do_hit(1, 1'b0);
    check_scores("pre_start");
    bus.BRICK_ROW = 3'd0; bus.RAM_PLAYER1 = 1'b1; bus.BRICK_HIT = 1'b1;
    bus.START_GAME = 1'b1;
    tick(1);
    bus.START_GAME = 1'b0;
    model_clear();
    tick(2);
    check("start_hit_busy", bus.BUSY, 1'b0);
    tick(10);
    bus.BRICK_HIT = 1'b0;
    check_scores("start_hit");
    tick(1);
    do_hit(4, 1'b1);
    check_scores("after_start_hit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/brick_score.md
BRICK_SCORE -- requirements
Module: brick_score

Interface
REQ-001 SHALL have parameter: BRICKS_PER_WALL, 112, brick hits per player that constitute a cleared wall.
REQ-002 SHALL have port: CLK_DRV  in  1  system clock; all state on its rising edge.
REQ-003 SHALL have port: RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: BRICK_HIT  in  1  hit level from brick_display, synchronous to CLK_DRV.
REQ-005 SHALL have port: BRICK_ROW  in  3  row of the struck brick (0 = top), valid on the BRICK_HIT rising edge.
REQ-006 SHALL have port: RAM_PLAYER1  in  1  1 = player 1 active, 0 = player 2.
REQ-007 SHALL have port: START_GAME  in  1  synchronous clear of scores and counts.
REQ-008 SHALL have port: ATTRACT_N  in  1  0 = attract mode, scoring inhibited.
REQ-009 SHALL have port: SCORE1, SCORE2  out  12  3-digit BCD score for each player.
REQ-010 SHALL have port: WALL_CLEARED  out  1  one-cycle pulse when the active player's count reaches BRICKS_PER_WALL.
REQ-011 SHALL have port: BUSY  out  1  high while points are being added.
REQ-012 SHALL have port: HIT_OVERRUN  out  1  one-cycle pulse when a hit is dropped.

Function
REQ-013 SHALL detect a hit as a 0->1 transition of BRICK_HIT between consecutive CLK_DRV samples, and only when ATTRACT_N=1.
REQ-014 SHALL map rows to points: rows 0-1 give 7, rows 2-3 give 5, rows 4-5 give 3, rows 6-7 give 1.
REQ-015 SHALL latch BRICK_ROW and RAM_PLAYER1 on the detect cycle; later changes SHALL NOT affect that hit.
REQ-016 SHALL use FSM states IDLE, LOAD, ADD and WALL.
REQ-017 SHALL transition IDLE->LOAD on a detected or pending hit; LOAD loads the point count, increments the latched player's brick count, then goes to ADD.
REQ-018 SHALL, in ADD, increment the latched player's BCD score by exactly 1 per cycle and decrement the point count; the last increment goes to WALL if the brick count equals BRICKS_PER_WALL, otherwise to IDLE.
REQ-019 SHALL, in WALL, pulse WALL_CLEARED for one cycle, zero that player's brick count, and go to IDLE.
REQ-020 SHALL make hit-to-final-score latency 2 + points cycles (9 cycles for a row-0 hit).
REQ-021 SHALL hold BUSY high in LOAD, ADD and WALL.
REQ-022 SHALL store a hit detected while BUSY=1 in a one-deep pending slot (row and player); the pending hit is served directly from IDLE.
REQ-023 SHALL discard a hit detected while the pending slot is full and pulse HIT_OVERRUN.
REQ-024 SHALL carry BCD digits 9->0; 999+1 wraps to 000 (see REQ-031).
REQ-025 SHALL let START_GAME=1 override everything: zero both scores, both counts and the pending slot, go to IDLE; a hit on the same cycle SHALL be ignored.
REQ-026 SHALL abort any ADD or pending hit when ATTRACT_N falls, finishing the current increment cycle only.
REQ-027 SHALL size the brick counters as clog2(BRICKS_PER_WALL+1) bits.

Reset
REQ-028 SHALL, while RESET_N=0, hold SCORE1=SCORE2=12'h000, WALL_CLEARED=0, BUSY=0 and HIT_OVERRUN=0, with FSM in IDLE, counts zero and pending slot empty.
REQ-029 SHALL, when reset asserts mid-ADD, discard any partial addition and not resume it after release.
REQ-030 SHALL NOT treat BRICK_HIT=1 in the first cycle after release as an edge (edge register resets to 1).

Configuration
REQ-031 SHALL, with BRICK_SCORE_SATURATE_EN defined, hold a score at 999 with no further change; without it, wrap per REQ-024.

Structure
REQ-032 SHALL place in package breakout_pkg: the FSM state enum, the row-to-points function/table and the BCD digit type.
REQ-033 SHALL implement one sub-module, bcd_counter3 (3-digit BCD incrementer with clear and saturate control), instantiated twice.

Verification
REQ-034 SHALL test: reset, START_GAME, row-0 hit as player 1 -> SCORE1 reaches 12'h007 nine cycles later, SCORE2=000.
REQ-035 SHALL test: row-6 hit as player 2 followed by row-2 hit 2 cycles later -> pending used, SCORE2=12'h006, no HIT_OVERRUN.
REQ-036 SHALL test: three hits 1 cycle apart while BUSY -> third dropped, HIT_OVERRUN pulses once.
REQ-037 SHALL test: 112 row-7 hits for player 1 -> SCORE1=12'h112, one WALL_CLEARED pulse, count back to 0.
REQ-038 SHALL test: score 995 plus row-0 hit -> 002 without the macro, 999 with BRICK_SCORE_SATURATE_EN.
REQ-039 SHALL test: RESET_N low mid-ADD and START_GAME coinciding with a hit -> all outputs zero, hit ignored.
